// File: rtl/sync_fifo_param.sv
// Purpose: single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags.
// Latency: 1 cycle from RREQ to RD/RVALID; with SYNC_FIFO_FWFT_EN, RD/RVALID show the head word while non-empty.
// Backpressure: writes are dropped while f (sets OVF); reads are dropped while e (sets UDF).
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   WREQ, WD        write request and write data
//   RREQ, RD        read request (a pop in FWFT mode) and read data
//   RVALID          RD holds a freshly popped word (FWFT: RD holds the head word)
//   f, e, af, ae    full, empty, almost-full (COUNT >= AF_LEVEL), almost-empty (COUNT <= AE_LEVEL)
//   COUNT           occupancy, 0..DEPTH
//   OVF, UDF        sticky overflow/underflow; ERR_CLR clears them (a set in the same cycle wins)
// Optional macro: SYNC_FIFO_FWFT_EN selects first-word fall-through read mode.
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WREQ,
   input  logic [WIDTH-1:0]         WD,
   input  logic                     RREQ,
   output logic [WIDTH-1:0]         RD,
   output logic                     RVALID,
   output logic                     f,
   output logic                     e,
   output logic                     af,
   output logic                     ae,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVF,
   output logic                     UDF,
   input  logic                     ERR_CLR
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance uses the pre-edge flags, so a full FIFO with both requests
   // pops only, and an empty FIFO with both requests pushes only.
   assign wr_acc = WREQ && !f;
   assign rd_acc = RREQ && !e;

   // Status flags decode from the registered count.
   assign e     = (count == '0);
   assign f     = (count == CW'(DEPTH));
   assign af    = (count >= CW'(AF_LEVEL));
   assign ae    = (count <= CW'(AE_LEVEL));
   assign COUNT = count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) mem[wptr] <= WD;
   end

   // Sticky error flags: a set in the same cycle as ERR_CLR wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         OVF <= 1'b0;
         UDF <= 1'b0;
      end else begin
         if (WREQ && f)    OVF <= 1'b1;
         else if (ERR_CLR) OVF <= 1'b0;
         if (RREQ && e)    UDF <= 1'b1;
         else if (ERR_CLR) UDF <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown combinationally; RD is forced to zero while empty so
   // stale storage never leaks out, and it reads zero after reset.
   assign RD     = e ? '0 : mem[rptr];
   assign RVALID = !e;
`else
   always_ff @(posedge clk) begin
      if (!rst) begin
         RD     <= '0;
         RVALID <= 1'b0;
      end else begin
         RVALID <= rd_acc;
         if (rd_acc) RD <= mem[rptr];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       WREQ = 1'b0;
   logic [7:0] WD = 8'h00;
   logic       RREQ = 1'b0;
   logic [7:0] RD;
   logic       RVALID;
   logic       f, e, af, ae;
   logic [3:0] COUNT;
   logic       OVF, UDF;
   logic       ERR_CLR = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .WREQ(WREQ), .WD(WD), .RREQ(RREQ), .RD(RD),
      .RVALID(RVALID), .f(f), .e(e), .af(af), .ae(ae), .COUNT(COUNT),
      .OVF(OVF), .UDF(UDF), .ERR_CLR(ERR_CLR)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({e, f, ae, af} !== 4'b1010) begin
         n_bad++;
         $display("FAIL reset_flags: got e,f,ae,af=%b want 1010", {e, f, ae, af});
      end
      n_cmp++;
      if (COUNT !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_count: got %0d want 0", COUNT);
      end
      n_cmp++;
      if ({OVF, UDF, RVALID} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_err_rvalid: got OVF,UDF,RVALID=%b want 000", {OVF, UDF, RVALID});
      end
      n_cmp++;
      if (RD !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_rd: got %h want 00", RD);
      end
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 8; i++) begin
         WREQ = 1'b1;
         WD   = 8'(i + 1);
         tick();
         n_cmp++;
         if ({COUNT, f, af, ae} !== {4'(i + 1), (i + 1 == 8), (i + 1 >= 6), (i + 1 <= 2)}) begin
            n_bad++;
            $display("FAIL fill_step%0d: got count=%0d f,af,ae=%b%b%b want count=%0d f,af,ae=%b%b%b",
                     i, COUNT, f, af, ae, i + 1, (i + 1 == 8), (i + 1 >= 6), (i + 1 <= 2));
         end
      end
      WREQ = 1'b0;
      for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         n_cmp++;
         if ({RVALID, RD} !== {1'b1, 8'(i + 1)}) begin
            n_bad++;
            $display("FAIL drain_word%0d: got rvalid=%b rd=%h want rvalid=1 rd=%h", i, RVALID, RD, 8'(i + 1));
         end
         RREQ = 1'b1;
         tick();
`else
         RREQ = 1'b1;
         tick();
         n_cmp++;
         if ({RVALID, RD} !== {1'b1, 8'(i + 1)}) begin
            n_bad++;
            $display("FAIL drain_word%0d: got rvalid=%b rd=%h want rvalid=1 rd=%h", i, RVALID, RD, 8'(i + 1));
         end
`endif
      end
      RREQ = 1'b0;
      tick();
      n_cmp++;
      if ({e, COUNT, RVALID} !== {1'b1, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL drain_end: got e=%b count=%0d rvalid=%b want e=1 count=0 rvalid=0", e, COUNT, RVALID);
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++;
      if (RD !== 8'h08) begin
         n_bad++;
         $display("FAIL drain_rd_hold: got %h want 08", RD);
      end
`endif
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 8; i++) begin
         WREQ = 1'b1;
         WD   = 8'(8'h21 + i);
         tick();
      end
      WREQ = 1'b0;
      n_cmp++;
      if ({f, COUNT} !== {1'b1, 4'd8}) begin
         n_bad++;
         $display("FAIL ovf_full: got f=%b count=%0d want f=1 count=8", f, COUNT);
      end
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++;
      if (RD !== 8'h21) begin
         n_bad++;
         $display("FAIL ovf_head: got %h want 21", RD);
      end
`endif
      WREQ = 1'b1;
      WD   = 8'hAA;
      RREQ = 1'b1;
      tick();
      WREQ = 1'b0;
      RREQ = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++;
      if ({RVALID, RD} !== {1'b1, 8'h21}) begin
         n_bad++;
         $display("FAIL ovf_read: got rvalid=%b rd=%h want rvalid=1 rd=21", RVALID, RD);
      end
`endif
      n_cmp++;
      if ({COUNT, OVF} !== {4'd7, 1'b1}) begin
         n_bad++;
         $display("FAIL ovf_set: got count=%0d ovf=%b want count=7 ovf=1", COUNT, OVF);
      end
      tick();
      tick();
      n_cmp++;
      if (OVF !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_sticky: got %b want 1", OVF);
      end
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      n_cmp++;
      if (OVF !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear: got %b want 0", OVF);
      end
      // Remaining words must be 22..28; the dropped AA must never surface.
      for (int i = 0; i < 7; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         n_cmp++;
         if (RD !== 8'(8'h22 + i)) begin
            n_bad++;
            $display("FAIL ovf_drain%0d: got %h want %h", i, RD, 8'(8'h22 + i));
         end
         RREQ = 1'b1;
         tick();
`else
         RREQ = 1'b1;
         tick();
         n_cmp++;
         if (RD !== 8'(8'h22 + i)) begin
            n_bad++;
            $display("FAIL ovf_drain%0d: got %h want %h", i, RD, 8'(8'h22 + i));
         end
`endif
      end
      RREQ = 1'b0;
      tick();
      n_cmp++;
      if (e !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_empty_end: got e=%b want 1", e);
      end
   endtask

   task automatic test_underflow;
      WREQ = 1'b1;
      WD   = 8'h55;
      RREQ = 1'b1;
      tick();
      WREQ = 1'b0;
      RREQ = 1'b0;
      n_cmp++;
      if ({COUNT, UDF} !== {4'd1, 1'b1}) begin
         n_bad++;
         $display("FAIL udf_set: got count=%0d udf=%b want count=1 udf=1", COUNT, UDF);
      end
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++;
      if ({RVALID, RD} !== {1'b1, 8'h55}) begin
         n_bad++;
         $display("FAIL udf_head: got rvalid=%b rd=%h want rvalid=1 rd=55", RVALID, RD);
      end
      RREQ = 1'b1;
      tick();
      RREQ = 1'b0;
`else
      n_cmp++;
      if (RVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL udf_rvalid: got %b want 0", RVALID);
      end
      RREQ = 1'b1;
      tick();
      RREQ = 1'b0;
      n_cmp++;
      if ({RVALID, RD} !== {1'b1, 8'h55}) begin
         n_bad++;
         $display("FAIL udf_read: got rvalid=%b rd=%h want rvalid=1 rd=55", RVALID, RD);
      end
`endif
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      n_cmp++;
      if ({e, UDF} !== 2'b10) begin
         n_bad++;
         $display("FAIL udf_clear: got e=%b udf=%b want e=1 udf=0", e, UDF);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         WREQ = 1'b1;
         WD   = 8'(8'h10 + i);
         tick();
      end
      WREQ = 1'b0;
      n_cmp++;
      if ({COUNT, af, ae} !== {4'd4, 2'b00}) begin
         n_bad++;
         $display("FAIL b2b_prefill: got count=%0d af,ae=%b%b want count=4 af,ae=00", COUNT, af, ae);
      end
      // 3*DEPTH simultaneous push/pop cycles; both pointers wrap several times.
      for (int k = 0; k < 24; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
         n_cmp++;
         if (RD !== 8'(8'h10 + k)) begin
            n_bad++;
            $display("FAIL b2b_word%0d: got %h want %h", k, RD, 8'(8'h10 + k));
         end
`endif
         WREQ = 1'b1;
         RREQ = 1'b1;
         WD   = 8'(8'h14 + k);
         tick();
`ifndef SYNC_FIFO_FWFT_EN
         n_cmp++;
         if ({RVALID, RD} !== {1'b1, 8'(8'h10 + k)}) begin
            n_bad++;
            $display("FAIL b2b_word%0d: got rvalid=%b rd=%h want rvalid=1 rd=%h", k, RVALID, RD, 8'(8'h10 + k));
         end
`endif
         n_cmp++;
         if (COUNT !== 4'd4) begin
            n_bad++;
            $display("FAIL b2b_count%0d: got %0d want 4", k, COUNT);
         end
      end
      WREQ = 1'b0;
      RREQ = 1'b0;
      for (int j = 0; j < 4; j++) begin
`ifdef SYNC_FIFO_FWFT_EN
         n_cmp++;
         if (RD !== 8'(8'h28 + j)) begin
            n_bad++;
            $display("FAIL b2b_tail%0d: got %h want %h", j, RD, 8'(8'h28 + j));
         end
         RREQ = 1'b1;
         tick();
`else
         RREQ = 1'b1;
         tick();
         n_cmp++;
         if (RD !== 8'(8'h28 + j)) begin
            n_bad++;
            $display("FAIL b2b_tail%0d: got %h want %h", j, RD, 8'(8'h28 + j));
         end
`endif
      end
      RREQ = 1'b0;
      tick();
      n_cmp++;
      if ({e, COUNT} !== {1'b1, 4'd0}) begin
         n_bad++;
         $display("FAIL b2b_end: got e=%b count=%0d want e=1 count=0", e, COUNT);
      end
   endtask

   task automatic test_reset_mid;
      RREQ = 1'b1;
      tick();
      RREQ = 1'b0;
      for (int i = 0; i < 5; i++) begin
         WREQ = 1'b1;
         WD   = 8'(8'h60 + i);
         tick();
      end
      n_cmp++;
      if ({COUNT, UDF} !== {4'd5, 1'b1}) begin
         n_bad++;
         $display("FAIL rstmid_pre: got count=%0d udf=%b want count=5 udf=1", COUNT, UDF);
      end
      // Reset lands in the middle of traffic with both requests still active.
      rst  = 1'b0;
      RREQ = 1'b1;
      tick();
      rst  = 1'b1;
      WREQ = 1'b0;
      RREQ = 1'b0;
      n_cmp++;
      if ({COUNT, e, f, ae, OVF, UDF, RVALID} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL rstmid_state: got count=%0d e,f,ae,ovf,udf,rvalid=%b want count=0 e,f,ae,ovf,udf,rvalid=101000",
                  COUNT, {e, f, ae, OVF, UDF, RVALID});
      end
      tick();
      n_cmp++;
      if ({COUNT, e, RD} !== {4'd0, 1'b1, 8'h00}) begin
         n_bad++;
         $display("FAIL rstmid_idle: got count=%0d e=%b rd=%h want count=0 e=1 rd=00", COUNT, e, RD);
      end
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft;
      WREQ = 1'b1;
      WD   = 8'h3C;
      tick();
      WREQ = 1'b0;
      n_cmp++;
      if ({RVALID, RD} !== {1'b1, 8'h3C}) begin
         n_bad++;
         $display("FAIL fwft_first: got rvalid=%b rd=%h want rvalid=1 rd=3c", RVALID, RD);
      end
      tick();
      n_cmp++;
      if ({RVALID, RD, COUNT} !== {1'b1, 8'h3C, 4'd1}) begin
         n_bad++;
         $display("FAIL fwft_hold: got rvalid=%b rd=%h count=%0d want rvalid=1 rd=3c count=1", RVALID, RD, COUNT);
      end
      RREQ = 1'b1;
      tick();
      RREQ = 1'b0;
      n_cmp++;
      if ({RVALID, e} !== 2'b01) begin
         n_bad++;
         $display("FAIL fwft_pop: got rvalid=%b e=%b want rvalid=0 e=1", RVALID, e);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
